// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, stall vector bits,
// ALU opcode encodings, ID->EX bus field offsets and the divider step.
package ex_stage_pkg;

  localparam int DW           = 32;
  localparam int ID_TO_EX_WD  = 145;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_ID_WD  = 38;
  localparam int STALL_W      = 6;

  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam int   STALL_EX  = 2;
  localparam int   STALL_MEM = 3;
  localparam logic STOP      = 1'b1;
  localparam logic NO_STOP   = 1'b0;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_NOR  = 5'd5,
    ALU_SLL  = 5'd6,
    ALU_SRL  = 5'd7,
    ALU_SRA  = 5'd8,
    ALU_SLT  = 5'd9,
    ALU_SLTU = 5'd10,
    ALU_LUI  = 5'd11,
    ALU_DIV  = 5'd12,
    ALU_DIVU = 5'd13
  } alu_op_e;

  // LSB positions of the ID->EX bus fields
  localparam int ID_RF_WADDR_LSB = 0;
  localparam int ID_RF_WE_BIT    = 5;
  localparam int ID_SEL_RES_BIT  = 6;
  localparam int ID_RAM_WEN_LSB  = 7;
  localparam int ID_RAM_EN_BIT   = 11;
  localparam int ID_ST_DATA_LSB  = 12;
  localparam int ID_SRC_B_LSB    = 44;
  localparam int ID_SRC_A_LSB    = 76;
  localparam int ID_ALU_OP_LSB   = 108;
  localparam int ID_PC_LSB       = 113;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // One restoring-division iteration: returns {remainder, quotient}.
  // The dividend is shifted out of the top of quo while quotient bits enter
  // at the bottom. A zero divisor always succeeds, giving all-ones.
  function automatic logic [63:0] div_step(input logic [31:0] rem,
                                           input logic [31:0] quo,
                                           input logic [31:0] dvs);
    logic [32:0] shifted;
    logic [32:0] trial;
    shifted = {rem, quo[31]};
    trial   = shifted - {1'b0, dvs};
    if (trial[32]) return {shifted[31:0], quo[30:0], 1'b0};
    else           return {trial[31:0], quo[30:0], 1'b1};
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for the execute stage.
// Only built when EX_DIV_EN is defined.
// The first iteration happens on the start edge, the remaining 31 in BUSY,
// so the quotient is presented in the 33rd cycle of the operation.
`ifdef EX_DIV_EN
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic        hold,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic        neg_q;
  logic [31:0] abs_a, abs_b;
  logic        neg_d;
  logic [63:0] step_first, step_next;

  assign abs_a = (is_signed && a[31]) ? (~a + 32'd1) : a;
  assign abs_b = (is_signed && b[31]) ? (~b + 32'd1) : b;
  // Divide by zero keeps the all-ones quotient regardless of dividend sign
  assign neg_d = is_signed && (a[31] ^ b[31]) && (b != 32'd0);

  assign step_first = div_step(32'd0, abs_a, abs_b);
  assign step_next  = div_step(rem_q, quo_q, dvs_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_IDLE;
    else     state_q <= state_d;
  end

  // Next state: DONE is released only once EX is allowed to advance
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (start) state_d = DIV_BUSY;
      DIV_BUSY: if (cnt_q == 5'd31) state_d = DIV_DONE;
      DIV_DONE: if (!hold) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // Datapath: load plus first iteration on start, then one iteration per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      neg_q <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            rem_q <= step_first[63:32];
            quo_q <= step_first[31:0];
            dvs_q <= abs_b;
            neg_q <= neg_d;
            cnt_q <= 5'd1;
          end
        end
        DIV_BUSY: begin
          rem_q <= step_next[63:32];
          quo_q <= step_next[31:0];
          cnt_q <= cnt_q + 5'd1;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign busy     = (state_q == DIV_BUSY);
  assign done     = (state_q == DIV_DONE);
  assign quotient = neg_q ? (~quo_q + 32'd1) : quo_q;

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: pipeline input register, single-cycle ALU, data memory
// request, forwarding bus. DIV/DIVU use the iterative divider when
// EX_DIV_EN is defined; otherwise they return 0 in one cycle.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  stall_bus_t              stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [DATA_W-1:0]       data_sram_addr,
  output logic [DATA_W-1:0]       data_sram_wdata,
  output logic                    stallreq_for_ex
);

  logic [ID_TO_EX_WD-1:0] id_q;
  alu_op_e     alu_op;
  logic [31:0] pc, src_a, src_b, st_data;
  logic        ram_en, sel_rf_res, rf_we;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result, div_res;
  logic        unused_stall;

  assign unused_stall = ^{stall[5:4], stall[1:0]};

  // Input register: bubble when EX stalls but MEM advances, load when EX advances
  always_ff @(posedge clk) begin
    if (rst)
      id_q <= '0;
    else if (stall[STALL_EX] == STOP && stall[STALL_MEM] == NO_STOP)
      id_q <= '0;
    else if (stall[STALL_EX] == NO_STOP)
      id_q <= id_to_ex_bus;
  end

  assign pc         = id_q[ID_PC_LSB +: 32];
  assign alu_op     = alu_op_e'(id_q[ID_ALU_OP_LSB +: 5]);
  assign src_a      = id_q[ID_SRC_A_LSB +: 32];
  assign src_b      = id_q[ID_SRC_B_LSB +: 32];
  assign st_data    = id_q[ID_ST_DATA_LSB +: 32];
  assign ram_en     = id_q[ID_RAM_EN_BIT];
  assign ram_wen    = id_q[ID_RAM_WEN_LSB +: 4];
  assign sel_rf_res = id_q[ID_SEL_RES_BIT];
  assign rf_we      = id_q[ID_RF_WE_BIT];
  assign rf_waddr   = id_q[ID_RF_WADDR_LSB +: 5];

`ifdef EX_DIV_EN
  logic        is_div, div_done, unused_div_busy;
  logic [31:0] div_quotient;

  assign is_div = (alu_op == ALU_DIV) || (alu_op == ALU_DIVU);

  div_iter u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div),
    .is_signed (alu_op == ALU_DIV),
    .hold      (stall[STALL_EX] == STOP),
    .a         (src_a),
    .b         (src_b),
    .busy      (unused_div_busy),
    .done      (div_done),
    .quotient  (div_quotient)
  );

  assign div_res         = div_done ? div_quotient : '0;
  assign stallreq_for_ex = is_div && !div_done;
`else
  assign div_res         = '0;
  assign stallreq_for_ex = 1'b0;
`endif

  // ALU: all non-divide results are combinational from the registered operands
  always_comb begin
    ex_result = '0;
    case (alu_op)
      ALU_ADD:  ex_result = src_a + src_b;
      ALU_SUB:  ex_result = src_a - src_b;
      ALU_AND:  ex_result = src_a & src_b;
      ALU_OR:   ex_result = src_a | src_b;
      ALU_XOR:  ex_result = src_a ^ src_b;
      ALU_NOR:  ex_result = ~(src_a | src_b);
      ALU_SLL:  ex_result = src_b << src_a[4:0];
      ALU_SRL:  ex_result = src_b >> src_a[4:0];
      ALU_SRA:  ex_result = $signed(src_b) >>> src_a[4:0];
      ALU_SLT:  ex_result = {31'b0, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: ex_result = {31'b0, src_a < src_b};
      ALU_LUI:  ex_result = {src_b[15:0], 16'b0};
      ALU_DIV,
      ALU_DIVU: ex_result = div_res;
      default:  ex_result = '0;
    endcase
  end

  assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
  assign ex_to_id_bus    = {rf_we, rf_waddr, ex_result};
  assign data_sram_en    = ram_en;
  assign data_sram_wen   = ram_wen;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = st_data;

endmodule
